// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, drives imem req/ack, feeds IF/ID; first valid_o one edge after the FETCH entry edge (zero-wait mem).
// Backpressure: stall_i holds the output, a one-entry skid absorbs the completing fetch; redirect flushes everything.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SQUASH, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, addr_q;
    logic [XLEN-1:0] skid_instr_q, skid_pc_q;
    logic [XLEN-1:0] rpc, addr_inc;
    logic            out_held, consume;

    assign rpc         = redirect_pc_i & ~XLEN'(3);
    assign addr_inc    = addr_q + XLEN'(4);
    assign out_held    = valid_o & stall_i;
    assign consume     = valid_o & ~stall_i;
    assign imem_addr_o = addr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!redirect_i && start_i) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack_i) begin
                    if (!redirect_i && out_held) state_d = S_HOLD;
                end else if (redirect_i) begin
                    state_d = S_SQUASH;
                end
            end
            S_SQUASH: if (imem_ack_i) state_d = S_FETCH;
            S_HOLD:   if (redirect_i || !stall_i) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_o = (state_q == S_FETCH) || (state_q == S_SQUASH);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            instr_o      <= '0;
            pc_o         <= '0;
            valid_o      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (redirect_i) begin
                        pc_q    <= rpc;
                        addr_q  <= rpc;
                        valid_o <= 1'b0;
                        instr_o <= '0;
                        pc_o    <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack_i && redirect_i) begin
                        pc_q    <= rpc;
                        addr_q  <= rpc;
                        valid_o <= 1'b0;
                        instr_o <= '0;
                        pc_o    <= '0;
                    end else if (imem_ack_i) begin
                        pc_q   <= addr_inc;
                        addr_q <= addr_inc;
                        // A completion is never refused; a stalled output diverts it into the skid.
                        if (out_held) begin
                            skid_instr_q <= imem_data_i;
                            skid_pc_q    <= addr_q;
                        end else begin
                            valid_o <= 1'b1;
                            instr_o <= imem_data_i;
                            pc_o    <= addr_q;
                        end
                    end else if (redirect_i || consume) begin
                        if (redirect_i) pc_q <= rpc;
                        valid_o <= 1'b0;
                        instr_o <= '0;
                        pc_o    <= '0;
                    end
                end
                S_SQUASH: begin
                    // The old request must finish; its data is dropped and the pending target issued next.
                    if (redirect_i) pc_q <= rpc;
                    if (imem_ack_i) addr_q <= redirect_i ? rpc : pc_q;
                    valid_o <= 1'b0;
                    instr_o <= '0;
                    pc_o    <= '0;
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        pc_q         <= rpc;
                        addr_q       <= rpc;
                        valid_o      <= 1'b0;
                        instr_o      <= '0;
                        pc_o         <= '0;
                        skid_instr_q <= '0;
                        skid_pc_q    <= '0;
                    end else if (!stall_i) begin
                        valid_o      <= 1'b1;
                        instr_o      <= skid_instr_q;
                        pc_o         <= skid_pc_q;
                        skid_instr_q <= '0;
                        skid_pc_q    <= '0;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-configurable instruction memory returning addr+0x100.
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_ack_i, valid_o;
    logic [31:0] imem_addr_o, imem_data_i, instr_o, pc_o;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int wait_cnt;

    if_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        imem_ack_i  = imem_req_o && (wait_cnt >= mem_lat - 1);
        imem_data_i = imem_addr_o + 32'h100;
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                        wait_cnt <= 0;
        else if (imem_req_o && imem_ack_i) wait_cnt <= 0;
        else if (imem_req_o)              wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'b0, valid_o}, {31'b0, v});
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_instr"}, instr_o, ins);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        #7;
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk_out("rst", 1'b0, 32'h0, 32'h0);
        rst_i = 1'b0;
        start_i = 1'b1;

        // Zero-wait streaming
        step(); start_i = 1'b0;
        chk("t1_e1_req", {31'b0, imem_req_o}, 32'd1);
        chk("t1_e1_valid", {31'b0, valid_o}, 32'd0);
        step(); chk_out("t1_e2", 1'b1, 32'h0, 32'h100);
        step(); chk_out("t1_e3", 1'b1, 32'h4, 32'h104);
        step(); chk_out("t1_e4", 1'b1, 32'h8, 32'h108);

        // Stall for three edges: skid takes 0xC
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_req", {31'b0, imem_req_o}, 32'd0);
            chk_out("t3_hold", 1'b1, 32'h8, 32'h108);
        end
        stall_i = 1'b0;
        step(); chk_out("t3_skid", 1'b1, 32'hC, 32'h10C);
        chk("t3_req_back", {31'b0, imem_req_o}, 32'd1);
        chk("t3_addr", imem_addr_o, 32'h10);
        step(); chk_out("t3_next", 1'b1, 32'h10, 32'h110);

        // Two-cycle memory
        mem_lat = 2;
        step(); chk_out("t2_gap0", 1'b0, 32'h0, 32'h0);
        chk("t2_addr0", imem_addr_o, 32'h14);
        chk("t2_req0", {31'b0, imem_req_o}, 32'd1);
        step(); chk_out("t2_hit0", 1'b1, 32'h14, 32'h114);
        step(); chk_out("t2_gap1", 1'b0, 32'h0, 32'h0);
        chk("t2_addr1", imem_addr_o, 32'h18);
        step(); chk_out("t2_hit1", 1'b1, 32'h18, 32'h118);

        // Redirect while a three-cycle request to 0x1C is pending
        mem_lat = 3;
        step(); chk("t4_pre_valid", {31'b0, valid_o}, 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        step(); redirect_i = 1'b0;
        chk_out("t4_flush", 1'b0, 32'h0, 32'h0);
        chk("t4_sq_req", {31'b0, imem_req_o}, 32'd1);
        chk("t4_sq_addr", imem_addr_o, 32'h1C);
        step(); chk("t4_new_addr", imem_addr_o, 32'h40);
        chk("t4_drop_valid", {31'b0, valid_o}, 32'd0);
        step(); chk("t4_wait1", {31'b0, valid_o}, 32'd0);
        step(); chk("t4_wait2", {31'b0, valid_o}, 32'd0);
        step(); chk_out("t4_first", 1'b1, 32'h40, 32'h140);

        // Redirect and ack in the same cycle, unaligned target
        mem_lat = 1;
        redirect_i = 1'b1; redirect_pc_i = 32'h203;
        step(); redirect_i = 1'b0;
        chk_out("t5_flush", 1'b0, 32'h0, 32'h0);
        chk("t5_addr", imem_addr_o, 32'h200);
        step(); chk_out("t5_first", 1'b1, 32'h200, 32'h300);

        // Asynchronous reset mid-request
        mem_lat = 3;
        #2 rst_i = 1'b1;
        #1;
        chk("t6_req", {31'b0, imem_req_o}, 32'd0);
        chk("t6_addr", imem_addr_o, 32'h0);
        chk_out("t6_rst", 1'b0, 32'h0, 32'h0);
        mem_lat = 1;
        rst_i = 1'b0; start_i = 1'b1;
        step(); start_i = 1'b0;
        step(); chk_out("t6_resume", 1'b1, 32'h0, 32'h100);

        // PC wrap at the top of the address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step(); redirect_i = 1'b0;
        chk("t6_wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        step(); chk_out("t6_wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h0000_00FC);
        chk("t6_wrap_addr1", imem_addr_o, 32'h0);
        step(); chk_out("t6_wrap_zero", 1'b1, 32'h0, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
